ysyx_25040129_mdu: RTL and testbench

Iterative RV32M multiply/divide unit that sits beside the EXU stage and shares its IDU→EXU→LSU valid/ready handshake. It accepts one M-extension operation at a time. It runs a 32-step shift-add multiply or restoring divide on operand magnitudes, fixes signs, and holds the result until the downstream stage takes it. While it is occupied, `busy_out` stalls the IDU.

---
 rtl/ysyx_25040129_mdu_pkg.sv | 33 +++
 rtl/ysyx_25040129_mdu_step.sv | 40 ++++
 rtl/ysyx_25040129_mdu.sv | 183 ++++++++++++++++++
 tb/tb_ysyx_25040129_mdu.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040129_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: widths, funct3 encodings,
// controller states and a small magnitude helper.
package ysyx_25040129_mdu_pkg;

    localparam int unsigned ysyx_25040129_XLEN     = 32;
    localparam int unsigned ysyx_25040129_REGS_DIG = 5;
    localparam int unsigned ysyx_25040129_CNT_W    = 5;

    localparam logic [2:0] ysyx_25040129_MD_MUL    = 3'd0;
    localparam logic [2:0] ysyx_25040129_MD_MULH   = 3'd1;
    localparam logic [2:0] ysyx_25040129_MD_MULHSU = 3'd2;
    localparam logic [2:0] ysyx_25040129_MD_MULHU  = 3'd3;
    localparam logic [2:0] ysyx_25040129_MD_DIV    = 3'd4;
    localparam logic [2:0] ysyx_25040129_MD_DIVU   = 3'd5;
    localparam logic [2:0] ysyx_25040129_MD_REM    = 3'd6;
    localparam logic [2:0] ysyx_25040129_MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ysyx_25040129_ST_IDLE = 2'd0,
        ysyx_25040129_ST_BUSY = 2'd1,
        ysyx_25040129_ST_FIX  = 2'd2,
        ysyx_25040129_ST_DONE = 2'd3
    } mdu_state_e;

    // Magnitude of v when it is treated as signed, otherwise v unchanged.
    function automatic logic [ysyx_25040129_XLEN-1:0] f_abs(
        input logic [ysyx_25040129_XLEN-1:0] v,
        input logic                          is_signed
    );
        return (is_signed && v[ysyx_25040129_XLEN-1]) ? ysyx_25040129_XLEN'(-v) : v;
    endfunction

endpackage

// File: rtl/ysyx_25040129_mdu_step.sv
// One combinational iteration of the MDU: shift-add multiply step or
// restoring-divide step on a 64-bit {hi, lo} working register.
module ysyx_25040129_mdu_step
    import ysyx_25040129_mdu_pkg::*;
(
    input  logic                            i_div,
    input  logic [2*ysyx_25040129_XLEN-1:0] i_acc,
    input  logic [ysyx_25040129_XLEN-1:0]   i_opnd,
    output logic [2*ysyx_25040129_XLEN-1:0] o_acc
);

    localparam int unsigned XL = ysyx_25040129_XLEN;

    logic [XL:0]          w_sum;
    logic [XL:0]          w_trial;
    logic                 w_ge;
    logic [XL-1:0]        w_diff;
    logic [2*XL-1:0]      w_shl;

    // Multiply: add multiplicand to the upper half when the multiplier LSB is set.
    assign w_sum = {1'b0, i_acc[2*XL-1:XL]} + (i_acc[0] ? {1'b0, i_opnd} : (XL+1)'(0));

    // Divide: partial remainder after the left shift can need one extra bit.
    assign w_shl   = {i_acc[2*XL-2:0], 1'b0};
    assign w_trial = i_acc[2*XL-1:XL-1];
    assign w_ge    = w_trial >= {1'b0, i_opnd};
    assign w_diff  = w_trial[XL-1:0] - i_opnd;

    always_comb begin
        o_acc = {w_sum, i_acc[XL-1:1]};
        if (i_div) begin
            if (w_ge) begin
                o_acc = {w_diff, w_shl[XL-1:1], 1'b1};
            end else begin
                o_acc = w_shl;
            end
        end
    end

endmodule

// File: rtl/ysyx_25040129_mdu.sv
// Iterative RV32M multiply/divide unit: controller FSM, step counter, sign handling
// and result register around the single-step datapath.
module ysyx_25040129_mdu
    import ysyx_25040129_mdu_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid_in,
    output logic                              req_ready_out,
    input  logic [2:0]                        md_op,
    input  logic [ysyx_25040129_XLEN-1:0]     src1,
    input  logic [ysyx_25040129_XLEN-1:0]     src2,
    input  logic [ysyx_25040129_REGS_DIG-1:0] rd_in,
    output logic                              resp_valid_out,
    input  logic                              resp_ready_in,
    output logic [ysyx_25040129_XLEN-1:0]     result_out,
    output logic [ysyx_25040129_REGS_DIG-1:0] rd_out,
    output logic                              busy_out,
    input  logic                              flush_in
);

    localparam int unsigned XL    = ysyx_25040129_XLEN;
    localparam int unsigned CNT_W = ysyx_25040129_CNT_W;

    mdu_state_e          r_state;
    mdu_state_e          w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_op;
    logic                r_neg_a;
    logic                r_neg_b;
    logic                r_fast;
    logic [2*XL-1:0]     r_acc;
    logic [XL-1:0]       r_opnd;

    logic                w_accept;
    logic                w_step;
    logic                w_fix;
    logic                w_is_div;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_div0;
    logic                w_ovf;
    logic                w_fast;
    logic [XL-1:0]       w_abs_a;
    logic [XL-1:0]       w_abs_b;
    logic [2*XL-1:0]     w_acc_nxt;
    logic [2*XL-1:0]     w_prod;
    logic [XL-1:0]       w_quot;
    logic [XL-1:0]       w_rem;
    logic [XL-1:0]       w_result;

    // Operand decode for the request currently presented.
    assign w_is_div   = md_op[2];
    assign w_a_signed = (md_op == ysyx_25040129_MD_MULH) || (md_op == ysyx_25040129_MD_MULHSU) ||
                        (md_op == ysyx_25040129_MD_DIV)  || (md_op == ysyx_25040129_MD_REM);
    assign w_b_signed = (md_op == ysyx_25040129_MD_MULH) || (md_op == ysyx_25040129_MD_DIV) ||
                        (md_op == ysyx_25040129_MD_REM);
    assign w_abs_a    = f_abs(src1, w_a_signed);
    assign w_abs_b    = f_abs(src2, w_b_signed);
    assign w_div0     = w_is_div && (src2 == '0);
    assign w_ovf      = ((md_op == ysyx_25040129_MD_DIV) || (md_op == ysyx_25040129_MD_REM)) &&
                        (src1 == {1'b1, {(XL-1){1'b0}}}) && (src2 == {XL{1'b1}});
    assign w_fast     = w_div0 || w_ovf;

    ysyx_25040129_mdu_step u_step (
        .i_div  (r_op[2]),
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .o_acc  (w_acc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ysyx_25040129_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Flush overrides every transition, including a pending response.
    always_comb begin
        w_state_nxt = r_state;
        if (flush_in) begin
            w_state_nxt = ysyx_25040129_ST_IDLE;
        end else begin
            unique case (r_state)
                ysyx_25040129_ST_IDLE: begin
                    if (req_valid_in) begin
                        w_state_nxt = w_fast ? ysyx_25040129_ST_FIX : ysyx_25040129_ST_BUSY;
                    end
                end
                ysyx_25040129_ST_BUSY: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = ysyx_25040129_ST_FIX;
                    end
                end
                ysyx_25040129_ST_FIX: begin
                    w_state_nxt = ysyx_25040129_ST_DONE;
                end
                ysyx_25040129_ST_DONE: begin
                    if (resp_ready_in) begin
                        w_state_nxt = ysyx_25040129_ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ysyx_25040129_ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        req_ready_out  = 1'b0;
        busy_out       = 1'b0;
        resp_valid_out = 1'b0;
        w_accept       = 1'b0;
        w_step         = 1'b0;
        w_fix          = 1'b0;
        req_ready_out  = (r_state == ysyx_25040129_ST_IDLE) && !flush_in;
        busy_out       = (r_state != ysyx_25040129_ST_IDLE);
        resp_valid_out = (r_state == ysyx_25040129_ST_DONE);
        w_accept       = req_valid_in && req_ready_out;
        w_step         = (r_state == ysyx_25040129_ST_BUSY) && !flush_in;
        w_fix          = (r_state == ysyx_25040129_ST_FIX) && !flush_in;
    end

    // Sign fix-up; preselected fast-path results skip negation.
    assign w_prod = (r_neg_a ^ r_neg_b) ? (2*XL)'(-r_acc) : r_acc;
    assign w_quot = r_fast ? r_acc[XL-1:0] :
                    ((r_neg_a ^ r_neg_b) ? XL'(-r_acc[XL-1:0]) : r_acc[XL-1:0]);
    assign w_rem  = r_fast ? r_acc[2*XL-1:XL] :
                    (r_neg_a ? XL'(-r_acc[2*XL-1:XL]) : r_acc[2*XL-1:XL]);

    always_comb begin
        w_result = w_prod[2*XL-1:XL];
        unique case (r_op)
            ysyx_25040129_MD_MUL:                         w_result = w_prod[XL-1:0];
            ysyx_25040129_MD_DIV, ysyx_25040129_MD_DIVU:  w_result = w_quot;
            ysyx_25040129_MD_REM, ysyx_25040129_MD_REMU:  w_result = w_rem;
            default:                                      w_result = w_prod[2*XL-1:XL];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_op       <= '0;
            r_neg_a    <= 1'b0;
            r_neg_b    <= 1'b0;
            r_fast     <= 1'b0;
            r_acc      <= '0;
            r_opnd     <= '0;
            result_out <= '0;
            rd_out     <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= md_op;
                rd_out  <= rd_in;
                r_neg_a <= w_a_signed && src1[XL-1];
                r_neg_b <= w_b_signed && src2[XL-1];
                r_fast  <= w_fast;
                r_opnd  <= w_abs_b;
                r_cnt   <= w_fast ? CNT_W'(0) : CNT_W'(XL-1);
                if (w_div0) begin
                    r_acc <= {src1, {XL{1'b1}}};
                end else if (w_ovf) begin
                    r_acc <= {{XL{1'b0}}, 1'b1, {(XL-1){1'b0}}};
                end else begin
                    r_acc <= {{XL{1'b0}}, w_abs_a};
                end
            end else if (w_step) begin
                r_acc <= w_acc_nxt;
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
            if (w_fix) begin
                result_out <= w_result;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25040129_mdu.sv
// Self-checking bench for ysyx_25040129_mdu: directed vector table, handshake corner
// sequences and randomized operations against an arithmetic reference model.
module tb_ysyx_25040129_mdu;
    import ysyx_25040129_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_in;
    logic        req_ready_out;
    logic [2:0]  md_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  rd_in;
    logic        resp_valid_out;
    logic        resp_ready_in;
    logic [31:0] result_out;
    logic [4:0]  rd_out;
    logic        busy_out;
    logic        flush_in;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[12];

    ysyx_25040129_mdu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .md_op          (md_op),
        .src1           (src1),
        .src2           (src2),
        .rd_in          (rd_in),
        .resp_valid_out (resp_valid_out),
        .resp_ready_in  (resp_ready_in),
        .result_out     (result_out),
        .rd_out         (rd_out),
        .busy_out       (busy_out),
        .flush_in       (flush_in)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: RV32M semantics via wide signed/unsigned arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic signed [31:0] sq;
        logic               ovf;
        logic [31:0]        r;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        case (op)
            3'd0: begin p = sa * sb; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0)   r = 32'hFFFF_FFFF;
                else if (ovf) r = 32'h8000_0000;
                else begin sq = $signed(a) / $signed(b); r = sq; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0)   r = a;
                else if (ovf) r = 32'h0;
                else begin sq = $signed(a) % $signed(b); r = sq; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed_div;
        signed_div = (op == 3'd4) || (op == 3'd6);
        if (op >= 3'd4 && (b == 0 || (signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    // Present one op (called #1 after a rising edge) and wait for resp_valid_out.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat);
        int busy_low;
        md_op = op; src1 = a; src2 = b; rd_in = rd; req_valid_in = 1'b1;
        check("req_ready_before_accept", 32'(req_ready_out), 32'd1);
        @(posedge clk); #1;
        req_valid_in = 1'b0;
        src1 = $urandom; src2 = $urandom; rd_in = 5'($urandom);
        lat = 0;
        busy_low = 0;
        while (lat < 100) begin
            if (!busy_out) busy_low++;
            if (lat > 0 && resp_valid_out) break;
            @(posedge clk); #1;
            lat++;
        end
        check("busy_during_op", 32'(busy_low), 32'd0);
    endtask

    task automatic complete();
        @(posedge clk); #1;
        check("idle_after_handshake_valid", 32'(resp_valid_out), 32'd0);
        check("idle_after_handshake_busy", 32'(busy_out), 32'd0);
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int         lat;
        logic [4:0] rd;
        rd = 5'($urandom);
        issue(op, a, b, rd, lat);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_result"}, result_out, exp);
        check({name, "_rd"}, 32'(rd_out), 32'(rd));
        complete();
    endtask

    initial begin
        int          lat;
        int          cnt;
        logic [2:0]  op;
        logic [31:0] a, b;

        tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
        tbl[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        tbl[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
        tbl[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
        tbl[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        tbl[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
        tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};

        rst_n = 1'b0; req_valid_in = 1'b0; md_op = '0; src1 = '0; src2 = '0;
        rd_in = '0; resp_ready_in = 1'b1; flush_in = 1'b0;
        #1;
        check("reset_result", result_out, 32'd0);
        check("reset_rd", 32'(rd_out), 32'd0);
        check("reset_resp_valid", 32'(resp_valid_out), 32'd0);
        check("reset_busy", 32'(busy_out), 32'd0);
        check("reset_req_ready", 32'(req_ready_out), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++)
            do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);

        // Backpressure: response held for 10 cycles, then new op right after handshake.
        resp_ready_in = 1'b0;
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd19, lat);
        check("bp_latency", 32'(lat), 32'd33);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_result_stable", result_out, 32'hFFFF_FFEB);
            check("bp_rd_stable", 32'(rd_out), 32'd19);
            check("bp_req_ready_low", 32'(req_ready_out), 32'd0);
            check("bp_resp_valid_high", 32'(resp_valid_out), 32'd1);
        end
        resp_ready_in = 1'b1;
        complete();
        do_op("bp_next", 3'd5, 32'd1000, 32'd3, 32'd333, 33);

        // Flush during BUSY: no response, then unit works normally.
        md_op = 3'd5; src1 = 32'd12345; src2 = 32'd10; rd_in = 5'd3; req_valid_in = 1'b1;
        @(posedge clk); #1;
        req_valid_in = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        flush_in = 1'b1;
        check("flush_blocks_ready", 32'(req_ready_out), 32'd0);
        @(posedge clk); #1;
        flush_in = 1'b0;
        check("flush_busy_low", 32'(busy_out), 32'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid_out) cnt++;
            @(posedge clk); #1;
        end
        check("flush_no_response", 32'(cnt), 32'd0);
        do_op("after_flush", 3'd6, 32'hFFFF_FF9C, 32'd7, model(3'd6, 32'hFFFF_FF9C, 32'd7), 33);

        // Reset in the middle of BUSY.
        md_op = 3'd1; src1 = 32'h1234_5678; src2 = 32'h8765_4321; rd_in = 5'd9; req_valid_in = 1'b1;
        @(posedge clk); #1;
        req_valid_in = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("midrst_result", result_out, 32'd0);
        check("midrst_rd", 32'(rd_out), 32'd0);
        check("midrst_resp_valid", 32'(resp_valid_out), 32'd0);
        check("midrst_busy", 32'(busy_out), 32'd0);
        check("midrst_req_ready", 32'(req_ready_out), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op("after_reset", 3'd1, 32'h1234_5678, 32'h8765_4321,
              model(3'd1, 32'h1234_5678, 32'h8765_4321), 33);

        // Randomized ops with biased corner operands.
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'hFFFF_FFFF;
                default: ;
            endcase
            do_op("rand", op, a, b, model(op, a, b), model_lat(op, a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
